instr_decode_block: RTL and testbench
=====================================

INSTR_DECODE_BLOCK -- requirements
Module: instr_decode_block

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on posedge clk only.
REQ-002 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-003 instr  input  16  instruction word: [15] imm_sel, [14:10] op, [9:8] rd, [7:6] rs (used when imm_sel=0), [7:0] imm8 (used when imm_sel=1).
REQ-004 instr_valid  input  1  fetch presents a valid instr.
REQ-005 instr_ready  output  1  decode accepts instr this cycle; transfer occurs when instr_valid & instr_ready.
REQ-006 ex_stall  input  1  execution stage cannot take a new operation; outputs hold.
REQ-007 wb_en  input  1  write-back strobe from execution result path.
REQ-008 wb_addr  input  2  write-back register index.
REQ-009 wb_data  input  8  write-back data (execution ans_ex).
REQ-010 op_dec  output  5  registered opcode to execution stage.
REQ-011 A  output  8  registered operand A = R[rd].
REQ-012 B  output  8  registered operand B = imm8 or R[rs].
REQ-013 rd_ex  output  2  registered destination index travelling with the operation.
REQ-014 out_valid  output  1  op_dec/A/B/rd_ex hold a newly issued operation.
REQ-015 stall_cnt  output  8  saturating count of hazard-stall cycles.

Function
REQ-016 Register file: 4 x 8-bit, R0-R3; written when wb_en=1 at posedge: R[wb_addr] <= wb_data.
REQ-017 Read bypass: a read of index matching wb_addr while wb_en=1 returns wb_data in that same cycle.
REQ-018 Writing ops: every op except 5'b00000 (NOP) and 5'b11111 (OUT) writes rd.
REQ-019 Scoreboard: busy[3:0]; on issue of a writing op, busy[rd] <= 1; on wb_en, busy[wb_addr] <= 0; same index set and cleared in one cycle -> set wins.
REQ-020 Hazard: hz = instr_valid & (eff_busy[rd] | (~imm_sel & eff_busy[rs])), where eff_busy[i] = busy[i] & ~(wb_en & wb_addr==i).
REQ-021 instr_ready = ~ex_stall & ~hz; reset asserted forces instr_ready=0.
REQ-022 Issue (instr_valid & instr_ready): next posedge op_dec<=op, A<=R[rd] (bypassed), B<=imm_sel ? imm8 : R[rs] (bypassed), rd_ex<=rd, out_valid<=1; latency exactly 1 cycle.
REQ-023 No issue and ex_stall=0: op_dec<=5'b00000 (bubble), out_valid<=0, A/B/rd_ex hold.
REQ-024 ex_stall=1: op_dec, A, B, rd_ex, out_valid all hold; busy still updates from wb_en.
REQ-025 stall_cnt increments by 1 on each cycle with instr_valid & hz & ~ex_stall; saturates at 8'hFF, never wraps.
REQ-026 Operation states: IDLE (out_valid=0), ISSUE (out_valid=1), HOLD (ex_stall=1 with out_valid=1); IDLE/ISSUE -> ISSUE on issue, -> IDLE on no issue; ISSUE -> HOLD on ex_stall; HOLD -> ISSUE/IDLE when ex_stall drops, per REQ-022/023.
REQ-027 Only one outstanding write per register; a second writer to a busy rd stalls via REQ-020 (rd is always read as A).

Reset
REQ-028 reset=0 at posedge: R0-R3=8'h00, busy=4'b0000, op_dec=5'b00000, A=B=8'h00, rd_ex=2'b00, out_valid=0, stall_cnt=8'h00, state IDLE.
REQ-029 Reset mid-operation (stalled or in HOLD) discards the pending instruction and all scoreboard entries; wb_en during reset is ignored.
REQ-030 First issue possible on the first posedge with reset=1.

Verification
REQ-031 After reset: wb R1=8'h40, wb R2=8'hC0; instr=16'h0580 (op 00001, rd=1, rs=2) valid -> next cycle op_dec=00001, A=8'h40, B=8'hC0, rd_ex=1, out_valid=1.
REQ-032 instr=16'h9208 (imm, op 00100, rd=2, imm 08) -> A=8'hC0, B=8'h08, rd_ex=2, busy[2]=1.
REQ-033 Issue writer to R1, then instr reading R1 -> instr_ready=0 and stall_cnt +1 per cycle; wb_en addr=1 data=8'h7F -> accepted that cycle, next cycle A=8'h7F.
REQ-034 wb_en addr=3 data=8'h5A in the same cycle as issue of op with rs=3 -> B=8'h5A.
REQ-035 ex_stall=1 for 3 cycles after an issue -> outputs constant, instr_ready=0, stall_cnt unchanged; drop -> next instr issues.
REQ-036 reset=0 while stalled on busy R1 -> all REQ-028 values next cycle; same instr then issues without stall.

Source files
------------

// File: rtl/instr_decode_block.sv
// Decode stage: 4x8 register file with write-back bypass, busy-bit scoreboard,
// hazard stall, and a registered issue port to the execution stage.
module instr_decode_block (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        ex_stall,
  input  logic        wb_en,
  input  logic [1:0]  wb_addr,
  input  logic [7:0]  wb_data,
  output logic [4:0]  op_dec,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [1:0]  rd_ex,
  output logic        out_valid,
  output logic [7:0]  stall_cnt
);
  localparam int NREG = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t                   state, state_nxt;
  logic [NREG-1:0][7:0]     rf;
  logic [NREG-1:0]          busy, busy_nxt, eff_busy;

  logic       imm_sel;
  logic [4:0] op;
  logic [1:0] rd, rs;
  logic [7:0] imm8, rd_val, rs_val;
  logic       hz, issue, writes;

  assign imm_sel = instr[15];
  assign op      = instr[14:10];
  assign rd      = instr[9:8];
  assign rs      = instr[7:6];
  assign imm8    = instr[7:0];

  // A write-back landing this cycle is visible to the read ports immediately.
  always_comb begin
    rd_val = (wb_en && wb_addr == rd) ? wb_data : rf[rd];
    rs_val = (wb_en && wb_addr == rs) ? wb_data : rf[rs];
  end

  always_comb begin
    eff_busy = busy;
    for (int i = 0; i < NREG; i++)
      if (wb_en && wb_addr == 2'(i)) eff_busy[i] = 1'b0;
  end

  assign hz          = instr_valid & (eff_busy[rd] | (~imm_sel & eff_busy[rs]));
  assign instr_ready = reset & ~ex_stall & ~hz;
  assign issue       = instr_valid & instr_ready;
  assign writes      = (op != 5'b00000) && (op != 5'b11111);

  // Set after clear so an issue claiming the register being retired wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_en)           busy_nxt[wb_addr] = 1'b0;
    if (issue && writes) busy_nxt[rd]      = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rf   <= '0;
      busy <= '0;
    end else begin
      if (wb_en) rf[wb_addr] <= wb_data;
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ex_stall) begin
      if (state == ISSUE) state_nxt = HOLD;
    end else begin
      state_nxt = issue ? ISSUE : IDLE;
    end
  end

  assign out_valid = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_dec <= '0;
      A      <= '0;
      B      <= '0;
      rd_ex  <= '0;
    end else if (!ex_stall) begin
      if (issue) begin
        op_dec <= op;
        A      <= rd_val;
        B      <= imm_sel ? imm8 : rs_val;
        rd_ex  <= rd;
      end else begin
        op_dec <= 5'b00000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      stall_cnt <= '0;
    else if (instr_valid && hz && !ex_stall && stall_cnt != 8'hFF)
      stall_cnt <= stall_cnt + 8'd1;
  end
endmodule

// File: tb/tb_instr_decode_block.sv
// Directed bench for instr_decode_block: hand-computed vectors for issue,
// bypass, scoreboard hazards, execution stall, reset and counter saturation.
module tb_instr_decode_block;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        ex_stall;
  logic        wb_en;
  logic [1:0]  wb_addr;
  logic [7:0]  wb_data;
  logic [4:0]  op_dec;
  logic [7:0]  A, B;
  logic [1:0]  rd_ex;
  logic        out_valid;
  logic [7:0]  stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_decode_block dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ex_stall(ex_stall), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .op_dec(op_dec), .A(A), .B(B),
    .rd_ex(rd_ex), .out_valid(out_valid), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] e_op, input logic [7:0] e_a,
                         input logic [7:0] e_b, input logic [1:0] e_rd, input logic e_ov);
    chk({tag, ".op"}, 16'(op_dec), 16'(e_op));
    chk({tag, ".A"},  16'(A),      16'(e_a));
    chk({tag, ".B"},  16'(B),      16'(e_b));
    chk({tag, ".rd"}, 16'(rd_ex),  16'(e_rd));
    chk({tag, ".ov"}, 16'(out_valid), 16'(e_ov));
  endtask

  initial begin
    reset = 1'b0; instr = '0; instr_valid = 1'b0; ex_stall = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    step(); step();
    chk_out("rst", 5'h00, 8'h00, 8'h00, 2'd0, 1'b0);
    chk("rst.cnt", 16'(stall_cnt), 16'h0);
    chk("rst.ready", 16'(instr_ready), 16'h0);

    // Preload R1/R2 through write-back
    reset = 1'b1;
    wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h40; step();
    wb_addr = 2'd2; wb_data = 8'hC0; step();
    wb_en = 1'b0;

    // Register-register issue, rd=1 rs=2
    instr = 16'h0580; instr_valid = 1'b1; #1;
    chk("rr.ready", 16'(instr_ready), 16'h1);
    step();
    chk_out("rr", 5'h01, 8'h40, 8'hC0, 2'd1, 1'b1);

    // Immediate issue, rd=2 imm 08
    instr = 16'h9208; step();
    chk_out("imm", 5'h04, 8'hC0, 8'h08, 2'd2, 1'b1);

    // R1 busy: rd=1 stalls and bubbles
    instr = 16'h0900; #1;
    chk("hz.ready", 16'(instr_ready), 16'h0);
    step();
    chk("hz.cnt1", 16'(stall_cnt), 16'h1);
    chk("hz.bub_op", 16'(op_dec), 16'h0);
    chk("hz.bub_ov", 16'(out_valid), 16'h0);
    step();
    chk("hz.cnt2", 16'(stall_cnt), 16'h2);
    wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h7F; #1;
    chk("wb.ready", 16'(instr_ready), 16'h1);
    step();
    chk_out("wbbyp", 5'h02, 8'h7F, 8'h00, 2'd1, 1'b1);
    chk("wb.cnt", 16'(stall_cnt), 16'h2);

    // Write-back to R3 bypassed into B in the issue cycle
    wb_addr = 2'd3; wb_data = 8'h5A; instr = 16'h0CC0; step();
    wb_en = 1'b0;
    chk_out("rsbyp", 5'h03, 8'h00, 8'h5A, 2'd0, 1'b1);

    // Execution stall with a hazarding instr pending: everything holds
    ex_stall = 1'b1; instr = 16'h0900;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("exs.ready", 16'(instr_ready), 16'h0);
      step();
      chk_out("exs", 5'h03, 8'h00, 8'h5A, 2'd0, 1'b1);
      chk("exs.cnt", 16'(stall_cnt), 16'h2);
    end
    ex_stall = 1'b0; instr = 16'h03C0; #1;
    chk("exs.rel_ready", 16'(instr_ready), 16'h1);
    step();
    chk_out("exs.rel", 5'h00, 8'h5A, 8'h5A, 2'd3, 1'b1);

    // No valid: bubble, operands hold
    instr_valid = 1'b0; step();
    chk_out("idle", 5'h00, 8'h5A, 8'h5A, 2'd3, 1'b0);

    // Stall on R1, then reset mid-stall with a write-back that must be ignored
    instr_valid = 1'b1; instr = 16'h0900; step();
    chk("pre.cnt", 16'(stall_cnt), 16'h3);
    reset = 1'b0; wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h33; #1;
    chk("rst2.ready", 16'(instr_ready), 16'h0);
    step();
    wb_en = 1'b0;
    chk_out("rst2", 5'h00, 8'h00, 8'h00, 2'd0, 1'b0);
    chk("rst2.cnt", 16'(stall_cnt), 16'h0);
    reset = 1'b1; #1;
    chk("post.ready", 16'(instr_ready), 16'h1);
    step();
    chk_out("post", 5'h02, 8'h00, 8'h00, 2'd1, 1'b1);

    // R1 now busy again: hold the hazard long enough to saturate the counter
    for (int i = 0; i < 260; i++) step();
    chk("sat.cnt", 16'(stall_cnt), 16'h00FF);
    chk("sat.ready", 16'(instr_ready), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
